// File: rtl/mmul_parallel_acc_drain_pkg.sv
// Shared types for the partial-sum accumulate/drain stage.
// Counters are carried internally at CNT_MAX_W bits; port widths (CNT_WIDTH) must not exceed it.
package mmul_parallel_package;

  localparam int unsigned CNT_MAX_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} acc_state_t;

  typedef struct packed {
    logic                 start;
    logic [CNT_MAX_W-1:0] n_acc;
    logic [CNT_MAX_W-1:0] n_out;
  } ctrl_acc_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [CNT_MAX_W-1:0] out_cnt;
  } flags_acc_t;

  // A zero accumulation length still means one beat per output element.
  function automatic logic [CNT_MAX_W-1:0] acc_len(input logic [CNT_MAX_W-1:0] n);
    return (n == '0) ? CNT_MAX_W'(1) : n;
  endfunction

endpackage

// File: rtl/mmul_parallel_acc_drain_if.sv
// Valid/ready data stream with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/mmul_parallel_acc_drain_add.sv
// Accumulator adder. MMUL_PARALLEL_ACC_SATURATE_EN selects signed clamping,
// otherwise two's-complement wrap.
module mmul_parallel_acc_add #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);
  logic [DATA_WIDTH-1:0] raw;
  assign raw = a_i + b_i;

`ifdef MMUL_PARALLEL_ACC_SATURATE_EN
  logic ovf;
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) && (raw[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);

  always_comb begin
    sum_o = raw;
    if (ovf)
      sum_o = a_i[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/mmul_parallel_acc_drain.sv
// Folds n_acc partial results per output element and streams out n_out sums per job.
// Optional MMUL_PARALLEL_ACC_SATURATE_EN: saturating adder (see mmul_parallel_acc_add).
module mmul_parallel_acc_drain
  import mmul_parallel_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   n_acc_i,
  input  logic [CNT_WIDTH-1:0]   n_out_i,
  hwpe_stream_intf_stream.sink   in_i,
  hwpe_stream_intf_stream.source out_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   out_cnt_o
);

  acc_state_t            state_q, state_d;
  ctrl_acc_t             ctrl;
  flags_acc_t            flags;
  logic [CNT_MAX_W-1:0]  n_acc_q, n_out_q, k_q, out_cnt_q;
  logic [DATA_WIDTH-1:0] acc_q, add_a, sum, out_data_q;
  logic                  out_valid_q, in_hs, out_hs, last_beat, last_out;

  always_comb begin
    ctrl       = '0;
    ctrl.start = start_i;
    ctrl.n_acc = CNT_MAX_W'(n_acc_i);
    ctrl.n_out = CNT_MAX_W'(n_out_i);
  end

  // Accept a beat only if the output register is free or draining this cycle.
  assign in_i.ready = (state_q == RUN) && (!out_valid_q || out_o.ready);
  assign in_hs      = in_i.valid && in_i.ready;
  assign out_hs     = out_valid_q && out_o.ready;
  assign last_beat  = in_hs && (k_q == n_acc_q - CNT_MAX_W'(1));
  assign last_out   = last_beat && (out_cnt_q + CNT_MAX_W'(1) == n_out_q);

  // First beat of an element loads rather than adds.
  assign add_a = (k_q == '0) ? '0 : acc_q;

  mmul_parallel_acc_add #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a_i   (add_a),
    .b_i   (in_i.data),
    .sum_o (sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl.start) state_d = (ctrl.n_out == '0) ? DONE : RUN;
      RUN:     if (last_out) state_d = DRAIN;
      DRAIN:   if (out_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_acc_q     <= '0;
      n_out_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (clear_i) begin
      k_q         <= '0;
      acc_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state_q == IDLE && ctrl.start) begin
        n_acc_q   <= acc_len(ctrl.n_acc);
        n_out_q   <= ctrl.n_out;
        k_q       <= '0;
        out_cnt_q <= '0;
      end
      if (in_hs) begin
        acc_q <= sum;
        k_q   <= last_beat ? '0 : k_q + CNT_MAX_W'(1);
      end
      if (last_beat) begin
        out_data_q  <= sum;
        out_valid_q <= 1'b1;
        out_cnt_q   <= out_cnt_q + CNT_MAX_W'(1);
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    flags         = '0;
    flags.busy    = (state_q == RUN) || (state_q == DRAIN);
    flags.done    = (state_q == DONE);
    flags.out_cnt = out_cnt_q;
  end

  assign busy_o     = flags.busy;
  assign done_o     = flags.done;
  assign out_cnt_o  = CNT_WIDTH'(flags.out_cnt);
  assign out_o.valid = out_valid_q;
  assign out_o.data  = out_data_q;
  assign out_o.strb  = '1;

endmodule

// File: tb/tb_mmul_parallel_acc_drain.sv
// Randomized bench for mmul_parallel_acc_drain against a queue-based sum model.
module tb_mmul_parallel_acc_drain;

  logic        clk = 1'b0;
  logic        rst_n, clear, start;
  logic [15:0] n_acc, n_out, out_cnt;
  logic        busy, done;
  int          total_n = 0;
  int          bad_n   = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_if ();

  always #5 clk = ~clk;

  mmul_parallel_acc_drain #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .start_i   (start),
    .n_acc_i   (n_acc),
    .n_out_i   (n_out),
    .in_i      (in_if),
    .out_o     (out_if),
    .busy_o    (busy),
    .done_o    (done),
    .out_cnt_o (out_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Signed 32-bit add: wraps, or clamps when the saturating build is selected.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef MMUL_PARALLEL_ACC_SATURATE_EN
    if (s > 64'sh7FFF_FFFF)  s = 64'sh7FFF_FFFF;
    if (s < -64'sh8000_0000) s = -64'sh8000_0000;
`endif
    return s[31:0];
  endfunction

  // mode: 0 random data, 1 counting 1..N, 2 alternating 0x7FFFFFFF / 1
  task automatic run_job(input int nacc, input int nout, input int hold, input int vpct,
                         input int rpct, input int clr_at, input int mode);
    logic [31:0] din[$];
    logic [31:0] exp_q[$];
    logic [31:0] s, prev_d;
    int eff, total, idx, nouts, cyc;
    bit fin, pend, prev_hold, cleared;
    eff   = (nacc == 0) ? 1 : nacc;
    total = eff * nout;
    for (int i = 0; i < total; i++)
      case (mode)
        1:       din.push_back(32'(i + 1));
        2:       din.push_back((i % 2 == 0) ? 32'h7FFF_FFFF : 32'h1);
        default: din.push_back($urandom);
      endcase
    for (int g = 0; g < nout; g++) begin
      s = din[g*eff];
      for (int j = 1; j < eff; j++) s = ref_add(s, din[g*eff+j]);
      exp_q.push_back(s);
    end

    @(negedge clk);
    start = 1'b1; n_acc = 16'(nacc); n_out = 16'(nout);
    @(negedge clk);
    start = 1'b0;
    idx = 0; nouts = 0; cyc = 0; fin = 0; pend = 0; prev_hold = 0; prev_d = '0; cleared = 0;
    while (cyc < 2000) begin
      if (prev_hold) begin
        chk("hold_valid", 64'(out_if.valid), 64'd1);
        chk("hold_data", 64'(out_if.data), 64'(prev_d));
      end
      if (done) begin fin = 1; break; end
      if (clr_at >= 0 && idx == clr_at) begin
        clear = 1'b1; in_if.valid = 1'b0; out_if.ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_ovalid", 64'(out_if.valid), 64'd0);
        chk("clr_out_cnt", 64'(out_cnt), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("clr_no_done", 64'(done), 64'd0);
        cleared = 1;
        break;
      end
      if (!pend) begin
        in_if.valid = (idx < total) && ($urandom_range(99) < 32'(vpct));
        in_if.data  = (idx < total) ? din[idx] : '0;
      end
      out_if.ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < 32'(rpct));
      #1;
      if (in_if.ready) chk("rdy_rule", 64'(busy && (!out_if.valid || out_if.ready)), 64'd1);
      if (out_if.valid && !out_if.ready) chk("backpress", 64'(in_if.ready), 64'd0);
      if (in_if.valid && in_if.ready) idx++;
      pend = in_if.valid && !in_if.ready;
      if (out_if.valid && out_if.ready) begin
        if (nouts < exp_q.size()) chk("out_data", 64'(out_if.data), 64'(exp_q[nouts]));
        else                      chk("extra_out", 64'(nouts), 64'(exp_q.size()));
        chk("strb", 64'(out_if.strb), 64'hF);
        nouts++;
      end
      prev_hold = out_if.valid && !out_if.ready;
      prev_d    = out_if.data;
      @(negedge clk);
      cyc++;
    end
    in_if.valid = 1'b0;
    if (cleared) return;
    chk("job_fin", 64'(fin), 64'd1);
    chk("beats", 64'(idx), 64'(total));
    chk("outs", 64'(nouts), 64'(nout));
    chk("out_cnt", 64'(out_cnt), 64'(nout));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; n_acc = '0; n_out = '0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '1; out_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_iready", 64'(in_if.ready), 64'd0);
    chk("rst_ovalid", 64'(out_if.valid), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_odata", 64'(out_if.data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(4, 2, 0, 100, 100, -1, 1);   // sums 10, 26
    run_job(1, 3, 5, 100, 100, -1, 0);   // output held off for 5 cycles
    run_job(2, 1, 0, 100, 100, -1, 2);   // overflow boundary
    run_job(0, 2, 0, 100, 100, -1, 0);   // n_acc 0 behaves as 1
    run_job(4, 2, 0, 100, 100, 3, 1);    // clear after 3 beats
    run_job(4, 2, 0, 100, 100, -1, 1);   // fresh job after clear

    // Empty job: done one cycle after start, nothing consumed.
    @(negedge clk);
    start = 1'b1; n_acc = 16'd3; n_out = 16'd0; in_if.valid = 1'b1; in_if.data = 32'h55;
    @(negedge clk);
    start = 1'b0;
    chk("nout0_done", 64'(done), 64'd1);
    chk("nout0_iready", 64'(in_if.ready), 64'd0);
    @(negedge clk);
    chk("nout0_done_end", 64'(done), 64'd0);
    chk("nout0_iready2", 64'(in_if.ready), 64'd0);
    in_if.valid = 1'b0;

    // Reset while draining.
    start = 1'b1; n_acc = 16'd1; n_out = 16'd1;
    @(negedge clk);
    start = 1'b0; in_if.valid = 1'b1; in_if.data = 32'h1234; out_if.ready = 1'b0;
    @(negedge clk);
    in_if.valid = 1'b0;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_ovalid", 64'(out_if.valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ovalid", 64'(out_if.valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_iready", 64'(in_if.ready), 64'd0);
    chk("mrst_odata", 64'(out_if.data), 64'd0);
    chk("mrst_out_cnt", 64'(out_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);

    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(50, 100)), int'($urandom_range(30, 100)), -1, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/mmul_parallel_acc_drain.md
MMUL_PARALLEL_ACC_DRAIN -- requirements
Module: mmul_parallel_acc_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data stream in and out.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the accumulation and output counters.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-006 SHALL have port start_i, input, 1: single-cycle job start.
REQ-007 SHALL have port n_acc_i, input, CNT_WIDTH: partial results per output element.
REQ-008 SHALL have port n_out_i, input, CNT_WIDTH: output elements per job.
REQ-009 SHALL have port in_i, hwpe_stream_intf_stream.sink, DATA_WIDTH: partial results from the engine out_r stream.
REQ-010 SHALL have port out_o, hwpe_stream_intf_stream.source, DATA_WIDTH: final sums to the streamer sink.
REQ-011 SHALL have port busy_o, output, 1: high in RUN and DRAIN.
REQ-012 SHALL have port done_o, output, 1: single-cycle pulse at job end.
REQ-013 SHALL have port out_cnt_o, output, CNT_WIDTH: output elements emitted in the current job.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-015 SHALL move IDLE->RUN on start_i, latching n_acc_i and n_out_i; a latched n_acc of 0 SHALL be treated as 1.
REQ-016 SHALL move IDLE->DONE on start_i when n_out_i==0.
REQ-017 SHALL ignore start_i outside IDLE.
REQ-018 SHALL drive in_i.ready = (state==RUN) && (!out_o.valid || out_o.ready).
REQ-019 On each input handshake, acc SHALL be loaded with in_i.data when k==0, else acc+in_i.data; k SHALL then increment.
REQ-020 On the handshake where k==n_acc-1: the sum SHALL be loaded into the output register, out_o.valid SHALL be set the next cycle (1-cycle latency), k SHALL reset to 0, and out_cnt SHALL increment.
REQ-021 Back-to-back operation SHALL be supported: while out_o.ready stays high, throughput SHALL be 1 input beat per cycle.
REQ-022 Once out_o.valid is set, out_o.data SHALL hold stable until out_o.ready is sampled high.
REQ-023 out_o.strb SHALL be all ones.
REQ-024 SHALL move RUN->DRAIN after the final output element is captured.
REQ-025 SHALL move DRAIN->DONE when that element handshakes.
REQ-026 SHALL move DONE->IDLE unconditionally; done_o SHALL be high only in DONE.
REQ-027 Without saturation, arithmetic SHALL be two's-complement, DATA_WIDTH, wrapping on overflow.
REQ-028 clear_i SHALL have priority over all events: state to IDLE; acc, k and out_cnt to 0; out_o.valid to 0; an input beat in that cycle SHALL be dropped.
REQ-029 Input beats in IDLE, DRAIN and DONE SHALL be back-pressured (ready low) and never lost.

Reset
REQ-030 On rst_ni low, the block SHALL immediately enter IDLE with acc, k, out_cnt, latched counts and out data at 0.
REQ-031 During reset, out_o.valid, in_i.ready, busy_o and done_o SHALL be 0.
REQ-032 Reset mid-job SHALL abandon the job with no done_o pulse.

Configuration
REQ-033 With MMUL_PARALLEL_ACC_SATURATE_EN defined, signed accumulation SHALL clamp to 0x7FFFFFFF / 0x80000000 (for DATA_WIDTH 32).
REQ-034 Without MMUL_PARALLEL_ACC_SATURATE_EN, signed accumulation SHALL wrap per REQ-027.

Structure
REQ-035 acc_state_t, ctrl_acc_t (start, n_acc, n_out) and flags_acc_t (busy, done, out_cnt) SHALL live in mmul_parallel_package.
REQ-036 The adder SHALL be the sub-module mmul_parallel_acc_add; the macro SHALL select saturating or wrapping mode inside it.

Verification
REQ-037 n_acc=4, n_out=2, inputs 1..8, ready=1 -> outputs 10 then 26; done_o pulses once; out_cnt_o=2.
REQ-038 n_acc=1, n_out=3, out ready low for 5 cycles -> in_i.ready low while the output register is full; data held stable; no beat lost.
REQ-039 n_acc=2, inputs 0x7FFFFFFF and 1 -> 0x7FFFFFFF with MMUL_PARALLEL_ACC_SATURATE_EN defined; 0x80000000 without.
REQ-040 clear_i asserted mid-job after 3 of 8 beats -> IDLE next cycle, out valid 0, out_cnt 0, no done_o; a fresh job gives correct sums.
REQ-041 start with n_out=0 -> done_o one cycle later; no input accepted.
REQ-042 rst_ni low during DRAIN -> all outputs 0 immediately; IDLE after release.
